// File: rtl/frame_buf_win_if.sv
// rtl/frame_buf_win_if.sv - write stream, window and random-read bundle for frame_buf_win
interface frame_buf_win_if #(
   parameter int DW   = 9,
   parameter int AW   = 16,
   parameter int NROW = 3,
   parameter int NRD  = 4
);
   logic                start;
   logic                wr_valid;
   logic                wr_ready;
   logic [DW-1:0]       wr_data;
   logic [AW-1:0]       wr_cnt;
   logic                busy;
   logic                frame_done;
   logic                win_en;
   logic [AW-1:0]       win_addr;
   logic [NROW*DW-1:0]  win_data;
   logic                win_valid;
   logic [NROW-1:0]     win_oob;
   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*DW-1:0]   rd_data;
   logic [NRD-1:0]      rd_valid;

   modport master (
      output start, wr_valid, wr_data, win_en, win_addr, rd_en, rd_addr,
      input  wr_ready, wr_cnt, busy, frame_done, win_data, win_valid, win_oob,
             rd_data, rd_valid
   );

   modport slave (
      input  start, wr_valid, wr_data, win_en, win_addr, rd_en, rd_addr,
      output wr_ready, wr_cnt, busy, frame_done, win_data, win_valid, win_oob,
             rd_data, rd_valid
   );
endinterface

// File: rtl/frame_buf_win.sv
// rtl/frame_buf_win.sv - single-frame pixel store with NROW-tap window and NRD random-read ports
module frame_buf_win #(
   parameter int DW    = 9,
   parameter int IMG_W = 180,
   parameter int IMG_H = 320,
   parameter int DEPTH = IMG_W * IMG_H,
   parameter int AW    = 16,
   parameter int NROW  = 3,
   parameter int NRD   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   frame_buf_win_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   logic [DW-1:0]   mem [DEPTH];
   state_t          state_q, state_d;
   logic [AW-1:0]   wr_cnt_q;
   logic            wr_accept;

   logic [AW+1:0]   tap_addr [NROW];
   logic [NROW-1:0] tap_oob;
   logic [DW-1:0]   win_q [NROW];
   logic [NROW-1:0] oob_q;
   logic            win_v_q;

   logic [DW-1:0]   rd_q [NRD];
   logic [NRD-1:0]  rd_v_q;

   // start has priority over a beat presented in the same cycle
   assign wr_accept = (state_q == FILL) && bus.wr_valid && !bus.start;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (bus.start) begin
            wr_cnt_q <= '0;
         end else if (wr_accept) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.start) state_d = FILL;
         FILL: begin
            if (bus.start) begin
               state_d = FILL;
            end else if (wr_accept && (wr_cnt_q == LAST)) begin
               state_d = DONE;
            end
         end
         DONE: if (bus.start) state_d = FILL;
         default: state_d = IDLE;
      endcase
   end

   // memory is never reset; a read in the same cycle as a write sees the old word
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_cnt_q] <= bus.wr_data;
      end
   end

   always_comb begin
      for (int k = 0; k < NROW; k++) begin
         tap_addr[k] = (AW+2)'(bus.win_addr) + (AW+2)'(k * IMG_W);
         tap_oob[k]  = (tap_addr[k] >= DEPTH_X);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_v_q <= 1'b0;
         oob_q   <= '0;
         for (int k = 0; k < NROW; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         win_v_q <= bus.win_en;
         if (bus.win_en) begin
            oob_q <= tap_oob;
            for (int k = 0; k < NROW; k++) begin
               win_q[k] <= tap_oob[k] ? '0 : mem[tap_addr[k][AW-1:0]];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_v_q <= '0;
         for (int p = 0; p < NRD; p++) begin
            rd_q[p] <= '0;
         end
      end else begin
         rd_v_q <= bus.rd_en;
         for (int p = 0; p < NRD; p++) begin
            if (bus.rd_en[p]) begin
               rd_q[p] <= ((AW+2)'(bus.rd_addr[p*AW +: AW]) >= DEPTH_X)
                          ? '0 : mem[bus.rd_addr[p*AW +: AW]];
            end
         end
      end
   end

   assign bus.wr_ready   = (state_q == FILL);
   assign bus.busy       = (state_q == FILL);
   assign bus.frame_done = (state_q == DONE);
   assign bus.wr_cnt     = wr_cnt_q;
   assign bus.win_valid  = win_v_q;
   assign bus.win_oob    = oob_q;
   assign bus.rd_valid   = rd_v_q;

   for (genvar k = 0; k < NROW; k++) begin : g_win
      assign bus.win_data[k*DW +: DW] = win_q[k];
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      assign bus.rd_data[p*DW +: DW] = rd_q[p];
   end

endmodule

// File: tb/tb_frame_buf_win.sv
// tb/tb_frame_buf_win.sv - directed table-driven bench for frame_buf_win
module tb_frame_buf_win;
   localparam int DW    = 9;
   localparam int AW    = 16;
   localparam int NROW  = 3;
   localparam int NRD   = 4;
   localparam int DEPTH = 57600;

   typedef struct {
      logic                win_en;
      logic [AW-1:0]       win_addr;
      logic [NROW*DW-1:0]  win_exp;
      logic [NROW-1:0]     oob_exp;
      logic [NRD-1:0]      rd_en;
      logic [NRD*AW-1:0]   rd_addr;
      logic [NRD*DW-1:0]   rd_exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t vec [7];

   frame_buf_win_if #(.DW(DW), .AW(AW), .NROW(NROW), .NRD(NRD)) bus ();

   frame_buf_win #(.DW(DW), .IMG_W(180), .IMG_H(320), .DEPTH(DEPTH),
                   .AW(AW), .NROW(NROW), .NRD(NRD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      vec[0] = '{1'b1, 16'd181,   {9'd29,  9'd361, 9'd181}, 3'b000, 4'b1111,
                 {16'd57599, 16'd512,   16'd511,   16'd0},   {9'd255, 9'd0,   9'd511, 9'd0}};
      vec[1] = '{1'b1, 16'd57500, {9'd0,   9'd0,   9'd156}, 3'b110, 4'b1111,
                 {16'd57344, 16'd60000, 16'd65535, 16'd1000}, {9'd0,   9'd0,   9'd0,   9'd488}};
      vec[2] = '{1'b1, 16'd0,     {9'd360, 9'd180, 9'd0},   3'b000, 4'b1111,
                 {16'd100,   16'd57599, 16'd180,   16'd1023}, {9'd100, 9'd255, 9'd180, 9'd511}};
      vec[3] = '{1'b1, 16'd57239, {9'd255, 9'd75,  9'd407}, 3'b000, 4'b1111,
                 {16'd57600, 16'd4,     16'd3,     16'd2},    {9'd0,   9'd4,   9'd3,   9'd2}};
      vec[4] = '{1'b1, 16'd57240, {9'd0,   9'd76,  9'd408}, 3'b100, 4'b0001,
                 {16'd9,     16'd9,     16'd9,     16'd5},    {9'd0,   9'd4,   9'd3,   9'd5}};
      vec[5] = '{1'b0, 16'd7,     {9'd0,   9'd76,  9'd408}, 3'b000, 4'b0000,
                 {16'd0,     16'd0,     16'd0,     16'd0},    {9'd0,   9'd4,   9'd3,   9'd5}};
      vec[6] = '{1'b1, 16'd359,   {9'd207, 9'd27,  9'd359}, 3'b000, 4'b1010,
                 {16'd600,   16'd0,     16'd77,    16'd0},    {9'd88,  9'd4,   9'd77,  9'd5}};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
      bus.win_en = 1'b0; bus.win_addr = '0; bus.rd_en = '0; bus.rd_addr = '0;
      step(); step();
      check("rst_wr_ready",   64'(bus.wr_ready),   64'd0);
      check("rst_busy",       64'(bus.busy),       64'd0);
      check("rst_frame_done", 64'(bus.frame_done), 64'd0);
      check("rst_wr_cnt",     64'(bus.wr_cnt),     64'd0);
      check("rst_win_valid",  64'(bus.win_valid),  64'd0);
      check("rst_win_oob",    64'(bus.win_oob),    64'd0);
      check("rst_win_data",   64'(bus.win_data),   64'd0);
      check("rst_rd_valid",   64'(bus.rd_valid),   64'd0);
      check("rst_rd_data",    64'(bus.rd_data),    64'd0);
      rst_n = 1'b1;

      // random-valid partial fill, then reset mid-fill
      bus.start = 1'b1; step(); bus.start = 1'b0;
      check("fill_busy",     64'(bus.busy),     64'd1);
      check("fill_wr_ready", 64'(bus.wr_ready), 64'd1);
      cnt = 0;
      for (int c = 0; c < 20000 && cnt < 3000; c++) begin
         bus.wr_valid = 1'($urandom_range(0, 1));
         bus.wr_data  = 9'(cnt % 512);
         if (bus.wr_valid) cnt++;
         step();
      end
      bus.wr_valid = 1'b0;
      check("rand_wr_cnt", 64'(bus.wr_cnt), 64'd3000);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("midrst_wr_cnt",     64'(bus.wr_cnt),     64'd0);
      check("midrst_busy",       64'(bus.busy),       64'd0);
      check("midrst_frame_done", 64'(bus.frame_done), 64'd0);
      check("midrst_wr_ready",   64'(bus.wr_ready),   64'd0);

      // full frame, wr_valid held high
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.wr_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.wr_data = 9'(i % 512);
         if (i == DEPTH - 1) begin
            check("pre_last_cnt",  64'(bus.wr_cnt),     64'(DEPTH - 1));
            check("pre_last_done", 64'(bus.frame_done), 64'd0);
         end
         step();
      end
      bus.wr_valid = 1'b0;
      check("full_wr_cnt",     64'(bus.wr_cnt),     64'(DEPTH));
      check("full_frame_done", 64'(bus.frame_done), 64'd1);
      check("full_wr_ready",   64'(bus.wr_ready),   64'd0);
      check("full_busy",       64'(bus.busy),       64'd0);
      step();
      check("done_hold", 64'(bus.frame_done), 64'd1);

      for (int v = 0; v < 7; v++) begin
         bus.win_en   = vec[v].win_en;
         bus.win_addr = vec[v].win_addr;
         bus.rd_en    = vec[v].rd_en;
         bus.rd_addr  = vec[v].rd_addr;
         step();
         check($sformatf("v%0d_win_valid", v), 64'(bus.win_valid), 64'(vec[v].win_en));
         for (int k = 0; k < NROW; k++)
            check($sformatf("v%0d_tap%0d", v, k), 64'(bus.win_data[k*DW +: DW]),
                  64'(vec[v].win_exp[k*DW +: DW]));
         if (vec[v].win_en)
            check($sformatf("v%0d_win_oob", v), 64'(bus.win_oob), 64'(vec[v].oob_exp));
         check($sformatf("v%0d_rd_valid", v), 64'(bus.rd_valid), 64'(vec[v].rd_en));
         for (int p = 0; p < NRD; p++)
            check($sformatf("v%0d_rd%0d", v, p), 64'(bus.rd_data[p*DW +: DW]),
                  64'(vec[v].rd_exp[p*DW +: DW]));
      end
      bus.win_en = 1'b0; bus.rd_en = '0;

      // restart from DONE, then read-before-write at address 50
      bus.start = 1'b1; step(); bus.start = 1'b0;
      check("restart_done", 64'(bus.frame_done), 64'd0);
      check("restart_cnt",  64'(bus.wr_cnt),     64'd0);
      check("restart_busy", 64'(bus.busy),       64'd1);
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         bus.wr_data = 9'(i);
         step();
      end
      bus.wr_data = 9'h1FF;
      bus.rd_en = 4'b0001; bus.rd_addr = 64'd50;
      step();
      check("rbw_old",     64'(bus.rd_data[DW-1:0]), 64'h032);
      check("rbw_wr_cnt",  64'(bus.wr_cnt),          64'd51);
      bus.wr_valid = 1'b0;
      step();
      check("rbw_new",     64'(bus.rd_data[DW-1:0]), 64'h1FF);
      bus.rd_en = '0;

      // start together with a beat at wr_cnt=100: beat dropped, count restarts
      bus.wr_valid = 1'b1;
      for (int i = 51; i < 100; i++) begin
         bus.wr_data = 9'(i);
         step();
      end
      check("mid_cnt100", 64'(bus.wr_cnt), 64'd100);
      bus.start = 1'b1; bus.wr_data = 9'h0AA;
      step();
      bus.start = 1'b0;
      check("mid_restart_cnt",  64'(bus.wr_cnt),     64'd0);
      check("mid_restart_done", 64'(bus.frame_done), 64'd0);
      check("mid_restart_busy", 64'(bus.busy),       64'd1);
      bus.wr_data = 9'h0BB;
      step();
      bus.wr_valid = 1'b0;
      check("mid_next_cnt", 64'(bus.wr_cnt), 64'd1);
      bus.rd_en = 4'b0011; bus.rd_addr = {16'd0, 16'd0, 16'd100, 16'd0};
      step();
      check("mid_addr0",   64'(bus.rd_data[0*DW +: DW]), 64'h0BB);
      check("mid_addr100", 64'(bus.rd_data[1*DW +: DW]), 64'd100);
      check("mid_done",    64'(bus.frame_done),          64'd0);
      bus.rd_en = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
